// File: rtl/control_sequencer.sv
// Microcoded control unit: a 0-4 step counter plus a combinational decode of
// opcode/step/flags into the control word for the 8-bit computer datapath.
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] instr,
  input  logic       FZ,
  input  logic       FC,
  output logic       HLT,
  output logic       MI,
  output logic       RI,
  output logic       RO,
  output logic       IO,
  output logic       II,
  output logic       AI,
  output logic       AO,
  output logic       EO,
  output logic       SU,
  output logic       BI,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step
);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } mode_e;

  logic [2:0] step_q;
  logic [2:0] step_d;
  logic [2:0] last_step;
  mode_e      mode_q;
  mode_e      mode_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 3'd0;
      mode_q <= RUN;
    end else begin
      step_q <= step_d;
      mode_q <= mode_d;
    end
  end

  // Final step index per opcode; undefined opcodes fall into the 3-cycle NOP case.
  always_comb begin
    last_step = 3'd2;
    case (instr)
      OP_LDA, OP_STA: last_step = 3'd3;
      OP_ADD, OP_SUB: last_step = 3'd4;
      default:        last_step = 3'd2;
    endcase
  end

  always_comb begin
    step_d = step_q;
    mode_d = mode_q;
    if (mode_q == RUN) begin
      if (step_q == 3'd2 && instr == OP_HLT) begin
        mode_d = HALTED;
      end else if (step_q >= last_step) begin
        step_d = 3'd0;
      end else begin
        step_d = step_q + 3'd1;
      end
    end
  end

  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (mode_q == HALTED) begin
      ctrl.hlt = 1'b1;
    end else begin
      case (step_q)
        3'd0: begin
          ctrl.co = 1'b1;
          ctrl.mi = 1'b1;
        end
        3'd1: begin
          ctrl.ro = 1'b1;
          ctrl.ii = 1'b1;
          ctrl.ce = 1'b1;
        end
        3'd2: begin
          case (instr)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ctrl.io = 1'b1;
              ctrl.mi = 1'b1;
            end
            OP_LDI: begin
              ctrl.io = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_JMP: begin
              ctrl.io = 1'b1;
              ctrl.j  = 1'b1;
            end
            OP_JC: begin
              ctrl.io = 1'b1;
              ctrl.j  = FC;
            end
            OP_JZ: begin
              ctrl.io = 1'b1;
              ctrl.j  = FZ;
            end
            OP_OUT: begin
              ctrl.ao = 1'b1;
              ctrl.oi = 1'b1;
            end
            OP_HLT:  ctrl.hlt = 1'b1;
            OP_NOP:  ctrl = '0;
            default: ctrl = '0;
          endcase
        end
        3'd3: begin
          case (instr)
            OP_LDA: begin
              ctrl.ro = 1'b1;
              ctrl.ai = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ctrl.ro = 1'b1;
              ctrl.bi = 1'b1;
            end
            OP_STA: begin
              ctrl.ao = 1'b1;
              ctrl.ri = 1'b1;
            end
            default: ctrl = '0;
          endcase
        end
        3'd4: begin
          if (instr == OP_ADD || instr == OP_SUB) begin
            ctrl.eo = 1'b1;
            ctrl.ai = 1'b1;
            ctrl.fi = 1'b1;
            ctrl.su = (instr == OP_SUB);
          end
        end
        default: ctrl = '0;
      endcase
    end
  end

  assign step = rst ? 3'd0 : step_q;
  assign HLT  = ctrl.hlt;
  assign MI   = ctrl.mi;
  assign RI   = ctrl.ri;
  assign RO   = ctrl.ro;
  assign IO   = ctrl.io;
  assign II   = ctrl.ii;
  assign AI   = ctrl.ai;
  assign AO   = ctrl.ao;
  assign EO   = ctrl.eo;
  assign SU   = ctrl.su;
  assign BI   = ctrl.bi;
  assign OI   = ctrl.oi;
  assign CE   = ctrl.ce;
  assign CO   = ctrl.co;
  assign J    = ctrl.j;
  assign FI   = ctrl.fi;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected (step, control word) pairs are
// queued per cycle from the microcode table and compared at the falling edge.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] instr;
  logic       FZ, FC;
  logic       HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI;
  logic [2:0] step;

  control_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .FZ(FZ), .FC(FC),
    .HLT(HLT), .MI(MI), .RI(RI), .RO(RO), .IO(IO), .II(II), .AI(AI), .AO(AO),
    .EO(EO), .SU(SU), .BI(BI), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI),
    .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_RI = 16'h2000,
                          B_RO  = 16'h1000, B_IO = 16'h0800, B_II = 16'h0400,
                          B_AI  = 16'h0200, B_AO = 16'h0100, B_EO = 16'h0080,
                          B_SU  = 16'h0040, B_BI = 16'h0020, B_OI = 16'h0010,
                          B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002,
                          B_FI  = 16'h0001;
  localparam logic [15:0] F0 = B_CO | B_MI;
  localparam logic [15:0] F1 = B_RO | B_II | B_CE;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  stp;
    logic [15:0] ctl;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [15:0] obs();
    return {HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI};
  endfunction

  function automatic void push(input logic [3:0] op, input logic [2:0] s, input logic [15:0] c);
    exp_t e;
    e.op = op; e.stp = s; e.ctl = c;
    sb.push_back(e);
  endfunction

  function automatic void push_fetch(input logic [3:0] op);
    push(op, 3'd0, F0);
    push(op, 3'd1, F1);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst = 1'b0;
    push_fetch(4'h1);
    push(4'h1, 3'd2, B_IO | B_MI);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL pre_reset step got %0d want %0d", step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL pre_reset ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++; if (step !== 3'd0) begin n_bad++; $display("FAIL in_reset step got %0d want 0", step); end
      n_cmp++; if (obs() !== 16'h0) begin n_bad++; $display("FAIL in_reset ctl got %h want 0000", obs()); end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    push_fetch(4'h0);
    push(4'h0, 3'd2, 16'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL post_reset step got %0d want %0d", step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL post_reset ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decode();
    exp_t e;
    FZ = 1'b0; FC = 1'b0;
    push_fetch(4'h1); push(4'h1, 3'd2, B_IO | B_MI); push(4'h1, 3'd3, B_RO | B_AI);
    push_fetch(4'h4); push(4'h4, 3'd2, B_IO | B_MI); push(4'h4, 3'd3, B_AO | B_RI);
    push_fetch(4'h5); push(4'h5, 3'd2, B_IO | B_AI);
    push_fetch(4'h6); push(4'h6, 3'd2, B_IO | B_J);
    push_fetch(4'hE); push(4'hE, 3'd2, B_AO | B_OI);
    push_fetch(4'hA); push(4'hA, 3'd2, 16'h0);
    push_fetch(4'h2); push(4'h2, 3'd2, B_IO | B_MI); push(4'h2, 3'd3, B_RO | B_BI);
    push(4'h2, 3'd4, B_EO | B_AI | B_FI);
    push_fetch(4'h3); push(4'h3, 3'd2, B_IO | B_MI); push(4'h3, 3'd3, B_RO | B_BI);
    push(4'h3, 3'd4, B_EO | B_AI | B_SU | B_FI);
    push_fetch(4'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL decode op%h step got %0d want %0d", e.op, step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL decode op%h ctl got %h want %h", e.op, obs(), e.ctl); end
      @(posedge clk); #1;
    end
    push(4'h0, 3'd2, 16'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL decode_tail ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jumps();
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      logic [3:0] op;
      logic       flag;
      op   = (k < 2) ? 4'h7 : 4'h8;
      flag = k[0];
      FC = (k < 2) ? flag : ~flag;
      FZ = (k < 2) ? ~flag : flag;
      push_fetch(op);
      push(op, 3'd2, B_IO | (flag ? B_J : 16'h0));
      while (sb.size() > 0) begin
        e = sb.pop_front(); instr = e.op;
        @(negedge clk);
        n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL jump%0d step got %0d want %0d", k, step, e.stp); end
        n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL jump%0d ctl got %h want %h", k, obs(), e.ctl); end
        @(posedge clk); #1;
      end
    end
  endtask

  // ADD then JC: the bench plays flag register, latching carry=1 on the FI edge.
  task automatic test_back_to_back();
    exp_t e;
    logic fi_seen;
    FC = 1'b0; FZ = 1'b0;
    push_fetch(4'h2); push(4'h2, 3'd2, B_IO | B_MI); push(4'h2, 3'd3, B_RO | B_BI);
    push(4'h2, 3'd4, B_EO | B_AI | B_FI);
    push_fetch(4'h7); push(4'h7, 3'd2, B_IO | B_J);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      fi_seen = FI;
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL b2b step got %0d want %0d", step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL b2b ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
      if (fi_seen === 1'b1) FC = 1'b1;
    end
    FC = 1'b0;
  endtask

  task automatic test_halt();
    exp_t e;
    push_fetch(4'hF); push(4'hF, 3'd2, B_HLT);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL hlt_entry step got %0d want %0d", step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL hlt_entry ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 12; i++) begin
      instr = 4'($urandom_range(0, 15)); FZ = 1'($urandom); FC = 1'($urandom);
      @(negedge clk);
      n_cmp++; if (step !== 3'd2) begin n_bad++; $display("FAIL halted%0d step got %0d want 2", i, step); end
      n_cmp++; if (obs() !== B_HLT) begin n_bad++; $display("FAIL halted%0d ctl got %h want %h", i, obs(), B_HLT); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs() !== 16'h0) begin n_bad++; $display("FAIL hlt_rst ctl got %h want 0000", obs()); end
    @(posedge clk); #1;
    rst = 1'b0; FZ = 1'b0; FC = 1'b0;
    push_fetch(4'h0); push(4'h0, 3'd2, 16'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL hlt_resume step got %0d want %0d", step, e.stp); end
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL hlt_resume ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_add();
    exp_t e;
    int   fi_count = 0;
    push_fetch(4'h2); push(4'h2, 3'd2, B_IO | B_MI);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = e.op;
      @(negedge clk);
      if (FI === 1'b1) fi_count++;
      n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL mid_add ctl got %h want %h", obs(), e.ctl); end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (FI === 1'b1) fi_count++;
    @(posedge clk); #1;
    rst = 1'b0;
    push_fetch(4'h2); push(4'h2, 3'd2, B_IO | B_MI);
    while (sb.size() > 0) begin
      e = sb.pop_front(); instr = (e.stp == 3'd0) ? 4'h2 : 4'h0;
      @(negedge clk);
      if (FI === 1'b1) fi_count++;
      n_cmp++; if (step !== e.stp) begin n_bad++; $display("FAIL mid_add_after step got %0d want %0d", step, e.stp); end
      if (e.stp == 3'd0) begin
        n_cmp++; if (obs() !== e.ctl) begin n_bad++; $display("FAIL mid_add_after ctl got %h want %h", obs(), e.ctl); end
      end
      @(posedge clk); #1;
    end
    n_cmp++; if (fi_count !== 0) begin n_bad++; $display("FAIL mid_add_fi count got %0d want 0", fi_count); end
    // last instruction above ran as NOP (instr=0 from T1 on), so step is back at 0
    @(negedge clk);
    n_cmp++; if (step !== 3'd0) begin n_bad++; $display("FAIL mid_add_end step got %0d want 0", step); end
  endtask

  initial begin
    rst = 1'b1; instr = 4'h0; FZ = 1'b0; FC = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_decode();
    test_jumps();
    test_back_to_back();
    test_halt();
    test_reset_mid_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
